// File: rtl/chrono_pkg.sv
// rtl/chrono_pkg.sv - state encoding, digit limits and BCD helpers for the chronometer
package chrono_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BCD_W    = 4;
    localparam int N_DIGITS = 7;
    localparam int MS_MAX   = 999;
    localparam int SEC_MAX  = 59;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [N_DIGITS-1:0][BCD_W-1:0] count_t;

    localparam bcd_t DIGIT_TOP    = bcd_t'(MS_MAX % 10);
    localparam bcd_t SEC_TENS_TOP = bcd_t'(SEC_MAX / 10);

    // One decade of the cascade: returns {carry_or_borrow, next_digit}.
    function automatic logic [BCD_W:0] bcd_step(input bcd_t d, input bcd_t top,
                                                input logic down, input logic en);
        logic [BCD_W:0] r;
        r = {1'b0, d};
        if (en) begin
            if (!down)
                r = (d == top) ? {1'b1, bcd_t'(0)} : {1'b0, d + bcd_t'(1)};
            else
                r = (d == bcd_t'(0)) ? {1'b1, top} : {1'b0, d - bcd_t'(1)};
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input bcd_t d);
        return d <= bcd_t'(9);
    endfunction

endpackage

// File: rtl/chrono_bcd_lap_if.sv
// rtl/chrono_bcd_lap_if.sv - control and display bundle of the chronometer
interface chrono_bcd_lap_if;
    import chrono_pkg::*;

    logic                      start_stop;
    logic                      lap;
    logic                      clear;
    logic                      mode;
    logic                      load;
    logic [7:0]                load_min;
    logic [7:0]                load_sec;
    logic [N_DIGITS*BCD_W-1:0] digits;
    logic                      running;
    logic                      lap_active;
    logic                      done;
    logic                      wrap;

    modport master (
        output start_stop, lap, clear, mode, load, load_min, load_sec,
        input  digits, running, lap_active, done, wrap
    );

    modport slave (
        input  start_stop, lap, clear, mode, load, load_min, load_sec,
        output digits, running, lap_active, done, wrap
    );

endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - count-unit prescaler; restarts from zero whenever disabled
module tick_gen #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count_q;

    assign tick = en && (count_q == LAST);

    // Holding at zero while disabled gives a full tick period after every resume.
    always_ff @(posedge clk) begin
        if (rst || !en || tick)
            count_q <= '0;
        else
            count_q <= count_q + W'(1);
    end

endmodule

// File: rtl/chrono_bcd_lap.sv
// rtl/chrono_bcd_lap.sv - mm:ss.mmm BCD stopwatch/countdown with lap freeze
module chrono_bcd_lap
    import chrono_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int MAX_MIN  = 59
) (
    input  logic            clk,
    input  logic            rst,
    chrono_bcd_lap_if.slave bus
);
    localparam int   DIV    = CLK_FREQ / TICK_HZ;
    localparam bcd_t MAX_M1 = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MAX_M0 = bcd_t'(MAX_MIN % 10);

    localparam count_t TOPS = {DIGIT_TOP, DIGIT_TOP, SEC_TENS_TOP, DIGIT_TOP,
                               DIGIT_TOP, DIGIT_TOP, DIGIT_TOP};
    localparam count_t COUNT_MAX = {MAX_M1, MAX_M0, SEC_TENS_TOP, DIGIT_TOP,
                                    DIGIT_TOP, DIGIT_TOP, DIGIT_TOP};

    state_t         state_q, state_d;
    count_t         count_q, count_d, stepped, digits_q, digits_d;
    logic           mode_q, mode_d;
    logic           lap_q, lap_d;
    logic           wrap_q, wrap_d;
    logic           tick, tick_en, do_tick;
    logic           at_max, at_floor, load_ok;
    logic           carry;
    logic [BCD_W:0] step_r;

    assign tick_en = (state_q == ST_RUN);

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    // Ripple carry/borrow through the decades, least significant ms digit first.
    always_comb begin
        stepped = count_q;
        carry   = 1'b1;
        step_r  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            step_r     = bcd_step(count_q[i], TOPS[i], mode_q, carry);
            stepped[i] = step_r[BCD_W-1:0];
            carry      = step_r[BCD_W];
        end
    end

    assign at_max   = (count_q == COUNT_MAX);
    assign at_floor = (count_q[N_DIGITS-1:1] == '0) && (count_q[0] <= bcd_t'(1));

    // BCD ordering matches numeric ordering once every digit is legal.
    assign load_ok = bcd_ok(bus.load_min[7:4]) && bcd_ok(bus.load_min[3:0])
                  && bcd_ok(bus.load_sec[7:4]) && bcd_ok(bus.load_sec[3:0])
                  && (bus.load_sec[7:4] <= SEC_TENS_TOP)
                  && (bus.load_min <= {MAX_M1, MAX_M0});

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mode_d   = mode_q;
        lap_d    = lap_q;
        wrap_d   = 1'b0;
        do_tick  = tick;
        digits_d = digits_q;

        if (bus.clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            lap_d   = 1'b0;
            do_tick = 1'b0;
        end else if (bus.load) begin
            if (state_q != ST_RUN && load_ok) begin
                count_d = {bus.load_min, bus.load_sec, 12'h000};
                if (state_q == ST_DONE)
                    state_d = ST_PAUSE;
            end
        end else if (bus.start_stop) begin
            case (state_q)
                ST_IDLE: begin
                    mode_d  = bus.mode;
                    state_d = (bus.mode && count_q == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    state_d = ST_PAUSE;
                    do_tick = 1'b0;
                end
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end else if (bus.lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
            lap_d = !lap_q;
        end

        if (do_tick) begin
            if (!mode_q) begin
                if (at_max) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = stepped;
                end
            end else if (at_floor) begin
                count_d = '0;
                state_d = ST_DONE;
            end else begin
                count_d = stepped;
            end
        end

        if (state_d == ST_DONE)
            lap_d = 1'b0;

        digits_d = lap_d ? digits_q : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            mode_q   <= 1'b0;
            lap_q    <= 1'b0;
            wrap_q   <= 1'b0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            lap_q    <= lap_d;
            wrap_q   <= wrap_d;
            digits_q <= digits_d;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.running    = (state_q == ST_RUN);
    assign bus.lap_active = lap_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_chrono_bcd_lap.sv
// tb/tb_chrono_bcd_lap.sv - scoreboard bench for chrono_bcd_lap against a millisecond model
module tb_chrono_bcd_lap;
    localparam int CLK_FREQ = 10;
    localparam int TICK_HZ  = 1;
    localparam int MAX_MIN  = 1;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int LIMIT    = (MAX_MIN + 1) * 60000;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    chrono_bcd_lap_if bus();

    chrono_bcd_lap #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [27:0] digits;
        bit          running;
        bit          lap_active;
        bit          done;
        int          wraps;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   dut_wraps = 0;
    bit   chk_req = 1'b0;

    // Reference model: whole count held as integer milliseconds.
    int m_ms = 0, m_st = S_IDLE, m_run_cyc = 0, m_shown = 0, m_wraps = 0;
    bit m_lap = 1'b0, m_down = 1'b0;

    function automatic logic [27:0] to_bcd(input int ms);
        int m, s, x;
        m = ms / 60000;
        s = (ms / 1000) % 60;
        x = ms % 1000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic bit legal(input logic [7:0] mn, input logic [7:0] sc);
        int a, b, c, d;
        a = int'(mn[7:4]); b = int'(mn[3:0]);
        c = int'(sc[7:4]); d = int'(sc[3:0]);
        return (a <= 9) && (b <= 9) && (c <= 9) && (d <= 9)
            && (c * 10 + d < 60) && (a * 10 + b <= MAX_MIN);
    endfunction

    function automatic int ms_of(input logic [7:0] mn, input logic [7:0] sc);
        return ((int'(mn[7:4]) * 10 + int'(mn[3:0])) * 60
              + int'(sc[7:4]) * 10 + int'(sc[3:0])) * 1000;
    endfunction

    function automatic void model_edge();
        int old_ms, old_st;
        bit tk;
        if (rst) begin
            m_ms = 0; m_st = S_IDLE; m_lap = 0; m_shown = 0; m_down = 0; m_run_cyc = 0;
            return;
        end
        old_ms = m_ms;
        old_st = m_st;
        tk = (m_st == S_RUN) && (m_run_cyc % DIV == DIV - 1);
        if (bus.clear) begin
            m_st = S_IDLE; m_ms = 0; m_lap = 0; tk = 0;
        end else if (bus.load) begin
            if (m_st != S_RUN && legal(bus.load_min, bus.load_sec)) begin
                m_ms = ms_of(bus.load_min, bus.load_sec);
                if (m_st == S_DONE) m_st = S_PAUSE;
            end
        end else if (bus.start_stop) begin
            if (m_st == S_IDLE) begin
                m_down = bus.mode;
                m_st   = (bus.mode && m_ms == 0) ? S_DONE : S_RUN;
            end else if (m_st == S_RUN) begin
                m_st = S_PAUSE; tk = 0;
            end else if (m_st == S_PAUSE) begin
                m_st = S_RUN;
            end
        end else if (bus.lap) begin
            if (m_st == S_RUN || m_st == S_PAUSE) m_lap = !m_lap;
        end
        if (tk) begin
            if (!m_down) begin
                m_ms = m_ms + 1;
                if (m_ms == LIMIT) begin m_ms = 0; m_wraps++; end
            end else if (m_ms <= 1) begin
                m_ms = 0; m_st = S_DONE;
            end else begin
                m_ms = m_ms - 1;
            end
        end
        if (m_st == S_DONE) m_lap = 0;
        if (!m_lap) m_shown = old_ms;
        m_run_cyc = (old_st == S_RUN && m_st == S_RUN) ? m_run_cyc + 1 : 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_ss();
        bus.start_stop = 1'b1;
        cycle();
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        cycle();
    endtask

    task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
        bus.load_min = mn;
        bus.load_sec = sc;
        bus.load     = 1'b1;
        cycle();
    endtask

    task automatic check(input string nm);
        exp_t e;
        e.name       = nm;
        e.digits     = to_bcd(m_shown);
        e.running    = (m_st == S_RUN);
        e.lap_active = m_lap;
        e.done       = (m_st == S_DONE);
        e.wraps      = m_wraps;
        exp_q.push_back(e);
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
    endtask

    function automatic void cmp(input string nm, input string field,
                                input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s.%s: got %h, expected %h", nm, field, act, req);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.wrap === 1'b1) dut_wraps++;
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                cmp("scoreboard", "empty_queue", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                cmp(e.name, "digits",     32'(bus.digits),     32'(e.digits));
                cmp(e.name, "running",    32'(bus.running),    32'(e.running));
                cmp(e.name, "lap_active", 32'(bus.lap_active), 32'(e.lap_active));
                cmp(e.name, "done",       32'(bus.done),       32'(e.done));
                cmp(e.name, "wrap_count", 32'(dut_wraps),      32'(e.wraps));
            end
        end
    end

    initial begin
        int r, mn, sc;
        bus.start_stop = 1'b0; bus.lap = 1'b0; bus.clear = 1'b0;
        bus.mode = 1'b0; bus.load = 1'b0; bus.load_min = 8'h00; bus.load_sec = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        check("reset");

        pulse_ss();
        run(10011);
        check("up_run");
        pulse_clear();

        do_load(8'h01, 8'h59);
        pulse_ss();
        run(10001);
        check("rollover");
        pulse_clear();

        bus.mode = 1'b1;
        do_load(8'h00, 8'h01);
        pulse_ss();
        run(10001);
        check("countdown_done");
        pulse_ss();
        run(2);
        check("done_ignores_start");
        pulse_clear();
        pulse_ss();
        run(1);
        check("down_from_zero");
        do_load(8'h00, 8'h02);
        run(1);
        check("load_in_done");
        pulse_clear();
        bus.mode = 1'b0;

        pulse_ss();
        run(5003);
        bus.lap = 1'b1;
        cycle();
        run(3000);
        check("lap_frozen");
        bus.lap = 1'b1;
        cycle();
        run(1);
        check("lap_release");
        pulse_clear();

        pulse_ss();
        run(2503);
        pulse_ss();
        run(50);
        check("pause_hold");
        bus.clear = 1'b1;
        bus.start_stop = 1'b1;
        cycle();
        run(1);
        check("clear_beats_start");

        do_load(8'h01, 8'h23);
        run(1);
        check("load_legal");
        do_load(8'h00, 8'h7A);
        run(1);
        check("load_bad_digit");
        do_load(8'h00, 8'h60);
        run(1);
        check("load_bad_sec");
        do_load(8'h02, 8'h00);
        run(1);
        check("load_bad_min");

        pulse_ss();
        run(1234);
        rst = 1'b1;
        cycle();
        check("rst_mid_run");
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            bus.mode = 1'($urandom);
            if (r < 2) begin
                bus.start_stop = 1'b1;
            end else if (r < 4) begin
                bus.lap = 1'b1;
            end else if (r < 5) begin
                if ($urandom_range(0, 1) == 0) begin
                    mn = $urandom_range(0, MAX_MIN);
                    sc = $urandom_range(0, 59);
                    bus.load_min = {4'(mn / 10), 4'(mn % 10)};
                    bus.load_sec = {4'(sc / 10), 4'(sc % 10)};
                end else begin
                    bus.load_min = 8'($urandom);
                    bus.load_sec = 8'($urandom);
                end
                bus.load = 1'b1;
            end else if (r == 5 && $urandom_range(0, 3) == 0) begin
                bus.clear = 1'b1;
            end
            cycle();
            if (i % 100 == 99) check("random");
        end

        run(3);
        if (exp_q.size() != 0) cmp("scoreboard", "leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
